// File: rtl/y86_ctrl_pkg.sv
// Shared definitions for the Y86-64 multi-cycle stage sequencer.
//   state_e      : sequencer states, one per instruction stage plus IDLE/HALT
//   ICODE_*      : Y86-64 instruction codes 0x0..0xB
//   STAT_*       : architectural status codes (AOK/HLT/ADR/INS)
//   needs_mem()  : instruction performs a data-memory access
//   needs_wb()   : instruction writes the register file
package y86_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        PCUPD,
        HALT
    } state_e;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    function automatic logic needs_mem(input logic [3:0] icode);
        return icode inside {ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
                             ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
    endfunction

    function automatic logic needs_wb(input logic [3:0] icode);
        return icode inside {ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_MRMOVQ, ICODE_OPQ,
                             ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
    endfunction

endpackage

// File: rtl/y86_req_timer.sv
// Memory request watchdog shared by the FETCH and MEMORY waits.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : force the count to zero (no request outstanding)
//   cnt_i       : request outstanding and not yet acknowledged this cycle
//   expired_o   : count has reached MEM_TIMEOUT-1
module y86_req_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic cnt_i,
    output logic expired_o
);

    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The sequencer leaves the wait state on expiry, so the count never wraps.
    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 core.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PCUPD,
// drives one-hot stage enables and write strobes, handshakes with the
// instruction and data memories and tracks architectural status.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   run                           : 1 = execute, 0 = stop at next instruction boundary
//   icode, instr_valid            : fetched instruction code and legality
//   imem_ready, imem_error        : instruction memory handshake / fault
//   dmem_ready, dmem_error        : data memory handshake / fault
//   imem_req, dmem_req            : memory requests, held until ready
//   fetch_en..wb_en               : one-hot stage enables
//   cc_we, reg_we, pc_we          : condition-code, register-file, PC write strobes
//   stat, halted, retired         : status code, halt flag, retired-instruction count
// Configuration macro: Y86_STAGE_SKIP_EN -- when defined, instructions without a
// data-memory access go straight from EXECUTE to WRITEBACK.
// All outputs are registered, decoded from the next state, so no input reaches
// an output combinationally and reset clears requests immediately.
module y86_seq_ctrl
    import y86_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_ready,
    input  logic             imem_error,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             cc_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_e             state_q, state_d;
    logic [3:0]         icode_q, icode_d;
    logic [2:0]         stat_q, stat_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic imem_req_q, dmem_req_q, fetch_en_q, decode_en_q, exec_en_q;
    logic mem_en_q, wb_en_q, cc_we_q, reg_we_q, pc_we_q, halted_q;

    logic tmr_clr, tmr_cnt, tmr_expired;

    // Timer runs only while a request is outstanding; any non-request cycle
    // (including the cycle before FETCH/MEMORY) returns it to zero.
    assign tmr_clr = !(imem_req_q || dmem_req_q);
    assign tmr_cnt = (imem_req_q && !imem_ready) || (dmem_req_q && !dmem_ready);

    y86_req_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .cnt_i     (tmr_cnt),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        icode_d   = icode_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                // Ready beats expiry; address fault beats illegal instruction.
                if (imem_ready) begin
                    if (imem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = HALT;
                    end else if (!instr_valid) begin
                        stat_d  = STAT_INS;
                        state_d = HALT;
                    end else begin
                        icode_d = icode;
                        state_d = DECODE;
                    end
                end else if (tmr_expired) begin
                    stat_d  = STAT_ADR;
                    state_d = HALT;
                end
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
`ifdef Y86_STAGE_SKIP_EN
                state_d = needs_mem(icode_q) ? MEMORY : WRITEBACK;
`else
                state_d = MEMORY;
`endif
            end
            MEMORY: begin
                // Non-memory instructions pass through in one cycle with no request.
                if (!needs_mem(icode_q)) begin
                    state_d = WRITEBACK;
                end else if (dmem_ready) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = HALT;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (tmr_expired) begin
                    stat_d  = STAT_ADR;
                    state_d = HALT;
                end
            end
            WRITEBACK: state_d = PCUPD;
            PCUPD: begin
                retired_d = retired_q + CNT_W'(1);
                if (icode_q == ICODE_HALT) begin
                    stat_d  = STAT_HLT;
                    state_d = HALT;
                end else begin
                    state_d = run ? FETCH : IDLE;
                end
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            icode_q     <= ICODE_HALT;
            stat_q      <= STAT_AOK;
            retired_q   <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            fetch_en_q  <= 1'b0;
            decode_en_q <= 1'b0;
            exec_en_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            cc_we_q     <= 1'b0;
            reg_we_q    <= 1'b0;
            pc_we_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            icode_q     <= icode_d;
            stat_q      <= stat_d;
            retired_q   <= retired_d;
            imem_req_q  <= (state_d == FETCH);
            dmem_req_q  <= (state_d == MEMORY) && needs_mem(icode_d);
            fetch_en_q  <= (state_d == FETCH);
            decode_en_q <= (state_d == DECODE);
            exec_en_q   <= (state_d == EXECUTE);
            mem_en_q    <= (state_d == MEMORY);
            wb_en_q     <= (state_d == WRITEBACK);
            cc_we_q     <= (state_d == EXECUTE) && (icode_d == ICODE_OPQ);
            reg_we_q    <= (state_d == WRITEBACK) && needs_wb(icode_d);
            pc_we_q     <= (state_d == PCUPD) && (icode_d != ICODE_HALT);
            halted_q    <= (state_d == HALT);
        end
    end

    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign fetch_en  = fetch_en_q;
    assign decode_en = decode_en_q;
    assign exec_en   = exec_en_q;
    assign mem_en    = mem_en_q;
    assign wb_en     = wb_en_q;
    assign cc_we     = cc_we_q;
    assign reg_we    = reg_we_q;
    assign pc_we     = pc_we_q;
    assign stat      = stat_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule
